multiplier_datapath: RTL and testbench
======================================

MULTIPLIER_DATAPATH -- requirements
Module: multiplier_datapath

Interface
REQ-001 The block SHALL have exactly one clock, Clk, and one reset, Reset, which is asynchronous and active-low.
REQ-002 Port: Clk  in  1  rising-edge clock.
REQ-003 Port: Reset  in  1  asynchronous active-low reset.
REQ-004 Port: SW  in  8  multiplicand S (two's complement), also the multiplier source on load.
REQ-005 Port: Clr_Ld  in  1  active-low; clear X and A, load B from SW.
REQ-006 Port: Shift_En  in  1  active-high; arithmetic right shift of the X:A:B chain.
REQ-007 Port: Add  in  1  active-high; X:A <= A + S.
REQ-008 Port: Sub  in  1  active-high; X:A <= A - S.
REQ-009 Port: Clr_XA  in  1  active-high; clear X and A, B held.
REQ-010 Port: Aval  out  8  register A, the product high byte.
REQ-011 Port: Bval  out  8  register B, the multiplier and then the product low byte.
REQ-012 Port: Xval  out  1  sign-extension bit X.
REQ-013 Port: M  out  1  equals B[0], combinational, feeding the control unit.

Function
REQ-014 All state (X, A, B) SHALL update only on the rising edge of Clk, except during reset.
REQ-015 Commands SHALL take effect at the first rising edge where they are sampled (1-cycle latency); outputs are registered, so there is no combinational input-to-output path except M from B.
REQ-016 Command priority SHALL be: Clr_Ld==0 > Clr_XA > Sub > Add > Shift_En > hold. Only the highest-priority asserted command executes in a cycle.
REQ-017 Load (Clr_Ld==0): X<=0; A<=0x00; B<=SW.
REQ-018 Clr_XA: X<=0; A<=0x00; B unchanged.
REQ-019 Add: sum9 = {A[7],A} + {S[7],S}, with any carry out of bit 8 discarded; X<=sum9[8]; A<=sum9[7:0]; B unchanged.
REQ-020 Sub: sum9 = {A[7],A} + ~{S[7],S} + 1, with carry out discarded; X and A are updated as for Add.
REQ-021 Shift_En: X<=X; A<={X,A[7:1]}; B<={A[0],B[7:1]}.
REQ-022 Hold (no command asserted): X, A and B SHALL retain their values indefinitely.
REQ-023 Add and Sub asserted together SHALL perform Sub only.
REQ-024 Shift_En asserted together with Add or Sub SHALL perform the add or subtract only; no shift occurs that cycle.
REQ-025 Edge cases SHALL be exact with no saturation: S=0x80 under Sub gives +128 in 9 bits; A=0x7F plus S=0x01 gives X=0, A=0x80.
REQ-026 SW SHALL be sampled only at edges where Load, Add or Sub executes; changes to SW at other times SHALL have no effect on state.

Reset
REQ-027 While Reset==0: X=0, A=0x00, B=0x00, so Aval=0x00, Bval=0x00, Xval=0 and M=0, asserted asynchronously without waiting for a Clk edge.
REQ-028 Reset asserted mid-multiply SHALL abort the operation immediately, with no partial update on the following edge.
REQ-029 After Reset deasserts, commands SHALL be honoured from the first rising edge.

Structure
REQ-030 Package mult_pkg SHALL hold DATA_W=8 and SUM_W=DATA_W+1; all widths in the block SHALL derive from these constants.
REQ-031 Sub-module adder_9 SHALL implement the 9-bit add/subtract: inputs a[8:0], b[8:0] and sub; output s[8:0]; subtract realised as invert-b plus carry-in.
REQ-032 The X, A and B registers SHALL reside in multiplier_datapath; adder_9 SHALL be purely combinational.

Verification
REQ-033 Reset low with arbitrary commands -> Aval=0x00, Bval=0x00, Xval=0 immediately; state holds after release with no command asserted.
REQ-034 SW=0xFD, Clr_Ld=0 for 1 cycle -> Bval=0xFD, Aval=0x00, Xval=0, M=1.
REQ-035 Scripted 8x(Add-if-M, Shift) then (Sub-if-M, Shift), with B=0xFD and S=0x07 -> Aval:Bval=0xFFEB (-21).
REQ-036 B=0x80, S=0x80, full scripted multiply -> Aval:Bval=0x4000 and Xval=0.
REQ-037 A=0x00, S=0x80, Sub -> Xval=0, Aval=0x80; A=0x7F, S=0x01, Add -> Xval=0, Aval=0x80.
REQ-038 Add+Sub asserted together with A=0x05, S=0x03 -> Aval=0x02; Clr_XA after a multiply -> X=0, A=0x00, Bval unchanged; Reset pulse mid-sequence -> all outputs 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared widths and command decode for the shift-add multiplier datapath.
// Every width in the block derives from DATA_W.
package mult_pkg;

  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 1;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_LOAD,
    CMD_CLR,
    CMD_SUB,
    CMD_ADD,
    CMD_SHIFT
  } cmd_e;

  // Collapse the raw strobes to the single command that wins this cycle.
  function automatic cmd_e cmd_decode(
    input logic clr_ld_n,
    input logic clr_xa,
    input logic sub,
    input logic add,
    input logic shift_en
  );
    cmd_e c;
    if (!clr_ld_n)    c = CMD_LOAD;
    else if (clr_xa)  c = CMD_CLR;
    else if (sub)     c = CMD_SUB;
    else if (add)     c = CMD_ADD;
    else if (shift_en) c = CMD_SHIFT;
    else              c = CMD_HOLD;
    return c;
  endfunction

endpackage

// File: rtl/adder_9.sv
// Combinational sign-extended add/subtract for the X:A accumulator.
// Subtract is invert-b with a carry-in of one; carry out is dropped.
module adder_9
  import mult_pkg::*;
(
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  input  logic             sub,
  output logic [SUM_W-1:0] s
);

  logic [SUM_W-1:0] b_eff;
  logic [SUM_W-1:0] cin;

  always_comb begin
    b_eff = sub ? ~b : b;
    cin   = {{(SUM_W-1){1'b0}}, sub};
    s     = a + b_eff + cin;
  end

endmodule

// File: rtl/multiplier_datapath.sv
// X:A:B register chain of the signed shift-add multiplier.
// M exposes B[0] to the external control unit.
module multiplier_datapath
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] SW,
  input  logic              Clr_Ld,
  input  logic              Shift_En,
  input  logic              Add,
  input  logic              Sub,
  input  logic              Clr_XA,
  output logic [DATA_W-1:0] Aval,
  output logic [DATA_W-1:0] Bval,
  output logic              Xval,
  output logic              M
);

  logic              x_q, x_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SUM_W-1:0]  sum;
  cmd_e              cmd;

  adder_9 u_add (
    .a   ({a_q[DATA_W-1], a_q}),
    .b   ({SW[DATA_W-1], SW}),
    .sub (Sub),
    .s   (sum)
  );

  always_comb begin
    cmd = cmd_decode(Clr_Ld, Clr_XA, Sub, Add, Shift_En);
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    unique case (cmd)
      CMD_LOAD: begin
        x_d = 1'b0;
        a_d = '0;
        b_d = SW;
      end
      CMD_CLR: begin
        x_d = 1'b0;
        a_d = '0;
      end
      CMD_SUB,
      CMD_ADD: begin
        x_d = sum[SUM_W-1];
        a_d = sum[DATA_W-1:0];
      end
      CMD_SHIFT: begin
        a_d = {x_q, a_q[DATA_W-1:1]};
        b_d = {a_q[0], b_q[DATA_W-1:1]};
      end
      CMD_HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign M    = b_q[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Scoreboard bench: driver pushes expected state, monitor pops and compares.
// Reference model is plain signed arithmetic over the X:A:B chain.
module tb_multiplier_datapath;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] SW = '0;
  logic       Clr_Ld = 1'b1;
  logic       Shift_En = 1'b0;
  logic       Add = 1'b0;
  logic       Sub = 1'b0;
  logic       Clr_XA = 1'b0;
  logic [7:0] Aval, Bval;
  logic       Xval, M;

  multiplier_datapath dut (
    .Clk(Clk), .Reset(Reset), .SW(SW), .Clr_Ld(Clr_Ld),
    .Shift_En(Shift_En), .Add(Add), .Sub(Sub), .Clr_XA(Clr_XA),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .M(M)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      nm;
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] msk;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       mx;
  logic [7:0] ma, mb;

  // Monitor: compares on every clock edge or on an asynchronous sample request.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge Clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ok = 1'b1;
        if (e.msk[3] && Xval !== e.x) ok = 1'b0;
        if (e.msk[2] && Aval !== e.a) ok = 1'b0;
        if (e.msk[1] && Bval !== e.b) ok = 1'b0;
        if (e.msk[0] && M !== e.b[0]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s: got X=%b A=%h B=%h M=%b, want X=%b A=%h B=%h (mask %b) t=%0t",
                   e.nm, Xval, Aval, Bval, M, e.x, e.a, e.b, e.msk, $time);
        end
      end
    end
  end

  function automatic void push_model(string nm);
    exp_t e;
    e.nm = nm; e.x = mx; e.a = ma; e.b = mb; e.msk = 4'hF;
    exp_q.push_back(e);
  endfunction

  // Reference: a single winning command, evaluated as signed integer arithmetic.
  task automatic step(input logic ld_n, input logic clr, input logic sb,
                      input logic ad, input logic sh, input logic [7:0] sw);
    int r;
    logic [8:0] s9;
    logic signed [16:0] chain;
    @(negedge Clk);
    Reset = 1'b1;
    Clr_Ld = ld_n; Clr_XA = clr; Sub = sb; Add = ad; Shift_En = sh; SW = sw;
    if (!ld_n) begin
      mx = 0; ma = 0; mb = sw;
    end else if (clr) begin
      mx = 0; ma = 0;
    end else if (sb || ad) begin
      r = int'($signed(ma)) + (sb ? -int'($signed(sw)) : int'($signed(sw)));
      s9 = r[8:0];
      mx = s9[8]; ma = s9[7:0];
    end else if (sh) begin
      chain = $signed({mx, ma, mb}) >>> 1;
      {mx, ma, mb} = chain;
    end
    push_model("cycle");
  endtask

  task automatic expect_now(string nm, logic x, logic [7:0] a,
                            logic [7:0] b, logic [3:0] msk);
    exp_t e;
    @(posedge Clk);
    #3;
    e.nm = nm; e.x = x; e.a = a; e.b = b; e.msk = msk;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  task automatic reset_pulse();
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    Clr_Ld = 1'($urandom); Clr_XA = 1'($urandom); Sub = 1'($urandom);
    Add = 1'($urandom); Shift_En = 1'($urandom); SW = 8'($urandom);
    mx = 0; ma = 0; mb = 0;
    push_model("reset_async");
    -> sample_ev;
    push_model("reset_edge");
  endtask

  task automatic multiply(input logic [7:0] b, input logic [7:0] s);
    step(0, 0, 0, 0, 0, b);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) step(1, 0, 0, mb[0], 0, s);
      else       step(1, 0, mb[0], 0, 0, s);
      step(1, 0, 0, 0, 1, 8'($urandom));
    end
  endtask

  initial begin
    mx = 0; ma = 0; mb = 0;
    #2;
    push_model("reset_initial");
    -> sample_ev;
    push_model("reset_hold");
    @(negedge Clk);
    step(1, 0, 0, 0, 0, 8'h5A);
    step(1, 0, 0, 0, 0, 8'hA5);

    step(0, 0, 0, 0, 0, 8'hFD);
    expect_now("load_fd", 0, 8'h00, 8'hFD, 4'hF);

    multiply(8'hFD, 8'h07);
    expect_now("prod_fd_x_07", 0, 8'hFF, 8'hEB, 4'b0110);

    step(1, 1, 0, 0, 0, 8'h33);
    expect_now("clr_xa_keeps_b", 0, 8'h00, 8'hEB, 4'hF);

    multiply(8'h80, 8'h80);
    expect_now("prod_80_x_80", 0, 8'h40, 8'h00, 4'b1110);

    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 0, 8'h80);
    expect_now("sub_min_s", 0, 8'h80, 8'h00, 4'b1100);

    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 1, 0, 8'h7F);
    step(1, 0, 0, 1, 0, 8'h01);
    expect_now("add_7f_01", 0, 8'h80, 8'h00, 4'b1100);

    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 1, 0, 8'h05);
    step(1, 0, 1, 1, 1, 8'h03);
    expect_now("add_and_sub", 0, 8'h02, 8'h00, 4'b0100);

    step(0, 0, 0, 0, 0, 8'h96);
    step(1, 0, 0, 1, 0, 8'h11);
    reset_pulse();
    expect_now("reset_mid", 0, 8'h00, 8'h00, 4'hF);
    step(1, 0, 0, 0, 0, 8'hFF);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse();
      else if ($urandom_range(0, 29) == 0)
        multiply(8'($urandom), 8'($urandom));
      else
        step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 0, 8'($urandom));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
